// File: rtl/multi_engine_dispatch.sv
// Multi-engine front/back end: round-robin job dispatch to NUM_ENGINES engines
// with outstanding-job limits, and packet-atomic round-robin result merging.
// Optional DISPATCH_STATS_EN adds job_cnt_out / pkt_cnt_out statistics counters.
module multi_engine_dispatch #(
  parameter int NUM_ENGINES     = 4,
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              si_valid_in,
  input  logic [DATA_WIDTH-1:0]             si_data_in,
  output logic                              si_rdy_out,
  output logic [NUM_ENGINES-1:0]            eng_valid_out,
  output logic [DATA_WIDTH-1:0]             eng_data_out,
  input  logic [NUM_ENGINES-1:0]            eng_rdy_in,
  input  logic [NUM_ENGINES-1:0]            res_valid_in,
  input  logic [NUM_ENGINES*DATA_WIDTH-1:0] res_data_in,
  input  logic [NUM_ENGINES-1:0]            res_last_in,
  output logic [NUM_ENGINES-1:0]            res_rdy_out,
  output logic                              so_valid_out,
  output logic [DATA_WIDTH-1:0]             so_data_out,
  output logic                              so_last_out,
  input  logic                              so_rdy_in,
  output logic                              busy_out,
  output logic                              err_out
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                       job_cnt_out,
  output logic [31:0]                       pkt_cnt_out
`endif
);

  localparam int IW = $clog2(NUM_ENGINES);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, PICK, SEND_HDR, SEND_BODY} disp_state_e;
  typedef enum logic       {M_IDLE, M_PKT} merge_state_e;

  disp_state_e             d_state_q, d_state_d;
  logic [DATA_WIDTH-1:0]   header_q, header_d;
  logic [15:0]             remaining_q, remaining_d;
  logic [IW-1:0]           sel_q, sel_d, dptr_q, dptr_d;
  merge_state_e            m_state_q, m_state_d;
  logic [IW-1:0]           gnt_q, gnt_d, mptr_q, mptr_d;
  logic [CW-1:0]           outstanding_q [NUM_ENGINES];
  logic [CW-1:0]           outstanding_d [NUM_ENGINES];
  logic                    err_q, err_d;

  logic [NUM_ENGINES-1:0]  eligible, inc_vec, dec_vec;
  logic                    any_out;
  logic                    pick_found, gnt_found, pick_fire, pkt_done;
  logic [IW-1:0]           pick_idx, gnt_idx;

  // First requester at or after ptr, wrapping; returns {found, index}.
  function automatic logic [IW:0] rr_pick(input logic [NUM_ENGINES-1:0] req,
                                          input logic [IW-1:0] ptr);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % NUM_ENGINES);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    return (p == IW'(NUM_ENGINES - 1)) ? '0 : IW'(p + 1'b1);
  endfunction

  assign {pick_found, pick_idx} = rr_pick(eligible, dptr_q);
  assign {gnt_found, gnt_idx}   = rr_pick(res_valid_in, mptr_q);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    d_state_d     = d_state_q;
    header_d      = header_q;
    remaining_d   = remaining_q;
    sel_d         = sel_q;
    dptr_d        = dptr_q;
    pick_fire     = 1'b0;
    si_rdy_out    = 1'b0;
    eng_valid_out = '0;
    eng_data_out  = header_q;
    case (d_state_q)
      IDLE: begin
        si_rdy_out = !rst;
        if (si_valid_in) begin
          header_d    = si_data_in;
          remaining_d = si_data_in[15:0];
          d_state_d   = PICK;
        end
      end
      PICK: begin
        if (pick_found) begin
          pick_fire = 1'b1;
          sel_d     = pick_idx;
          dptr_d    = next_ptr(pick_idx);
          d_state_d = SEND_HDR;
        end
      end
      SEND_HDR: begin
        eng_valid_out[sel_q] = 1'b1;
        if (eng_rdy_in[sel_q]) d_state_d = (remaining_q == '0) ? IDLE : SEND_BODY;
      end
      SEND_BODY: begin
        // Body words bypass any buffering: the chosen engine back-pressures the input.
        eng_valid_out[sel_q] = si_valid_in;
        eng_data_out         = si_data_in;
        si_rdy_out           = eng_rdy_in[sel_q];
        if (si_valid_in && eng_rdy_in[sel_q]) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == 16'd1) d_state_d = IDLE;
        end
      end
      default: d_state_d = IDLE;
    endcase
  end

  always_comb begin
    m_state_d    = m_state_q;
    gnt_d        = gnt_q;
    mptr_d       = mptr_q;
    pkt_done     = 1'b0;
    res_rdy_out  = '0;
    so_valid_out = 1'b0;
    so_data_out  = '0;
    so_last_out  = 1'b0;
    case (m_state_q)
      M_IDLE: begin
        if (gnt_found) begin
          gnt_d     = gnt_idx;
          m_state_d = M_PKT;
        end
      end
      M_PKT: begin
        so_valid_out       = res_valid_in[gnt_q];
        so_data_out        = res_data_in[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
        so_last_out        = res_valid_in[gnt_q] & res_last_in[gnt_q];
        res_rdy_out[gnt_q] = so_rdy_in;
        if (res_valid_in[gnt_q] && so_rdy_in && res_last_in[gnt_q]) begin
          pkt_done  = 1'b1;
          mptr_d    = next_ptr(gnt_q);
          m_state_d = M_IDLE;
        end
      end
      default: m_state_d = M_IDLE;
    endcase
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (pick_fire) inc_vec[pick_idx] = 1'b1;
    if (pkt_done)  dec_vec[gnt_q]    = 1'b1;
  end

  always_comb begin
    any_out = 1'b0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      eligible[i] = outstanding_q[i] < MAX_CNT;
      if (outstanding_q[i] != '0) any_out = 1'b1;
    end
  end

  // A simultaneous dispatch and completion on one engine cancels out.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      outstanding_d[i] = outstanding_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        outstanding_d[i] = outstanding_q[i] + 1'b1;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (outstanding_q[i] == '0) err_d = 1'b1;
        else outstanding_d[i] = outstanding_q[i] - 1'b1;
      end
    end
  end

  assign busy_out = (d_state_q != IDLE) || any_out;
  assign err_out  = err_q;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_state_q   <= IDLE;
      header_q    <= '0;
      remaining_q <= '0;
      sel_q       <= '0;
      dptr_q      <= '0;
      m_state_q   <= M_IDLE;
      gnt_q       <= '0;
      mptr_q      <= '0;
      err_q       <= 1'b0;
      // NOTE: the counter array is small control state, so it is reset like any flop.
      for (int i = 0; i < NUM_ENGINES; i++) outstanding_q[i] <= '0;
    end else begin
      d_state_q     <= d_state_d;
      header_q      <= header_d;
      remaining_q   <= remaining_d;
      sel_q         <= sel_d;
      dptr_q        <= dptr_d;
      m_state_q     <= m_state_d;
      gnt_q         <= gnt_d;
      mptr_q        <= mptr_d;
      err_q         <= err_d;
      outstanding_q <= outstanding_d;
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [31:0] job_cnt_q, pkt_cnt_q;
  logic        hdr_xfer;

  assign hdr_xfer = (d_state_q == SEND_HDR) && eng_rdy_in[sel_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_cnt_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      if (hdr_xfer) job_cnt_q <= job_cnt_q + 32'd1;
      if (pkt_done) pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign job_cnt_out = job_cnt_q;
  assign pkt_cnt_out = pkt_cnt_q;
`endif

endmodule

// File: doc/multi_engine_dispatch.md
# multi_engine_dispatch

Parametrised front/back end that scales the single Smith Waterman engine to NUM_ENGINES engines on one clock. Accepts query jobs (header word followed by query sequence blocks) from the stream input path, assigns each whole job to an engine with spare capacity by round-robin, and merges the engines' result packets back into one output stream with packet-atomic round-robin arbitration. Tracks outstanding jobs per engine so no engine holds more than MAX_OUTSTANDING jobs.

## Interface
- NUM_ENGINES, 4, engines served (2..16)
- DATA_WIDTH, 128, stream word width (>= 32)
- MAX_OUTSTANDING, 2, max jobs in flight per engine (1..7)

- clk  in  1  engine clock
- rst  in  1  reset, asynchronous, active-high
- si_valid_in  in  1  job word valid
- si_data_in  in  DATA_WIDTH  job word; header bits [15:0] = num_query_blocks, [31:16] = query_id, rest opaque
- si_rdy_out  out  1  job word accepted
- eng_valid_out  out  NUM_ENGINES  one-hot valid to engine input streams
- eng_data_out  out  DATA_WIDTH  word broadcast to all engines
- eng_rdy_in  in  NUM_ENGINES  engine input ready
- res_valid_in  in  NUM_ENGINES  per-engine result valid
- res_data_in  in  NUM_ENGINES*DATA_WIDTH  per-engine result word, engine i at [i*DATA_WIDTH +: DATA_WIDTH]
- res_last_in  in  NUM_ENGINES  final word of a result packet
- res_rdy_out  out  NUM_ENGINES  result word accepted
- so_valid_out / so_data_out / so_last_out  out  1 / DATA_WIDTH / 1  merged result stream
- so_rdy_in  in  1  downstream ready
- busy_out  out  1  any job in flight or dispatch FSM not IDLE
- err_out  out  1  sticky: result packet end from engine with zero outstanding

## Operation
- Handshake: word transfers when valid & ready on same edge; valid, once high, holds with stable data until transfer.
- Dispatch FSM: IDLE, PICK, SEND_HDR, SEND_BODY.
  - IDLE: si_rdy_out=1; on transfer, latch header, remaining=num_query_blocks; -> PICK.
  - PICK: si_rdy_out=0; eligible = outstanding[i] < MAX_OUTSTANDING; if any, sel = first eligible at or after dispatch pointer (wrap), outstanding[sel]++, pointer=sel+1 mod N; -> SEND_HDR. Otherwise stay.
  - SEND_HDR: eng_valid_out[sel]=1, eng_data_out=header; on eng_rdy_in[sel]: -> IDLE if remaining==0, else SEND_BODY.
  - SEND_BODY: combinational passthrough: eng_valid_out[sel]=si_valid_in, eng_data_out=si_data_in, si_rdy_out=eng_rdy_in[sel]; remaining-- per transfer; transfer with remaining==1 -> IDLE.
- Merge FSM: M_IDLE, M_PKT.
  - M_IDLE: res_rdy_out=0, so_valid_out=0; if any res_valid_in, gnt = first valid at or after merge pointer; -> M_PKT.
  - M_PKT: passthrough from gnt; res_rdy_out[gnt]=so_rdy_in; on last-word transfer: outstanding[gnt]--, pointer=gnt+1 mod N, -> M_IDLE.
- Same-cycle increment and decrement of one engine: count unchanged.
- Decrement at zero: count stays 0, err_out set until reset.
- Outstanding counters width clog2(MAX_OUTSTANDING+1); never exceed MAX_OUTSTANDING.
- eng_data_out = header when not SEND_BODY.

## Timing
- Reset values: si_rdy_out=0 during reset (1 in IDLE after), eng_valid_out=0, res_rdy_out=0, so_valid_out=0, so_last_out=0, so_data_out=0, busy_out=0, err_out=0; pointers 0, counters 0.
- Header accepted cycle T -> eng_valid_out[sel] high at T+2 earliest.
- Body latency 0 cycles (combinational); one bubble per job (PICK) minimum.
- Result packet: first word on so_* one cycle after valid seen in M_IDLE; one idle cycle between packets.
- Reset mid-job: all FSMs to IDLE, partial job discarded; engines reset by same rst.

## Configuration
- DISPATCH_STATS_EN defined: adds outputs job_cnt_out[31:0] (increments on each SEND_HDR transfer) and pkt_cnt_out[31:0] (increments on each so last-word transfer), both wrap at 2^32, reset 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset, NUM_ENGINES=4: four jobs of 3 blocks each, all rdy high -> headers on engines 0,1,2,3; each engine gets 4 words; header reaches eng bus 2 cycles after acceptance.
- MAX_OUTSTANDING=2, no results returned: 9 jobs -> 8 dispatched (2 per engine), 9th stalls in PICK with si_rdy_out=0, busy_out=1; one result packet end from engine 2 -> 9th goes to engine 2.
- Job with num_query_blocks=0 -> only header sent, FSM returns to IDLE after header transfer.
- Engines 1 and 3 present 2-word packets simultaneously, so_rdy_in toggling 1,0,1 -> packets output unbroken, engine 1 first, then 3; so_last_out on 2nd word of each.
- Result last from engine 0 with outstanding 0 -> err_out=1, counter stays 0; same cycle PICK selects engine whose packet ends -> count unchanged.
- DISPATCH_STATS_EN: 5 jobs, 5 packets -> job_cnt_out=5, pkt_cnt_out=5; assert rst mid-body -> all outputs to reset values next cycle.
